// File: rtl/pulse_to_level.sv
// pulse_to_level: stretches strobes into HIGH_CYCLES windows + GAP_CYCLES gaps, queuing extras.
// Define RETRIGGER_EN to make pulses during a window extend it instead of queuing.
module pulse_to_level #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int PEND_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pulse_in,
  input  logic                  overflow_clr,
  output logic                  level_out,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending_count,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  localparam logic [CNT_WIDTH-1:0]  HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  last, retrig, enq, deq, drop;
  always_comb begin
    last = cnt_q == '0;
`ifdef RETRIGGER_EN
    retrig = pulse_in && state_q == HIGH;
`else
    retrig = 1'b0;
`endif
    enq = pulse_in && state_q != IDLE && !retrig;
    deq = state_q == GAP && last && pend_q != '0;
    drop = enq && !deq && pend_q == PEND_MAX;
    state_d = state_q;
    cnt_d = (state_q == IDLE) ? cnt_q : cnt_q - 1'b1;
    if (state_q == IDLE && pulse_in) begin
      state_d = HIGH;
      cnt_d = HIGH_LOAD;
    end else if (retrig) begin
      cnt_d = HIGH_LOAD;
    end else if (state_q == HIGH && last) begin
      state_d = GAP;
      cnt_d = GAP_LOAD;
    end else if (state_q == GAP && last) begin
      state_d = deq ? HIGH : IDLE;
      cnt_d = deq ? HIGH_LOAD : '0;
    end
    pend_d = (enq && !deq && !drop) ? pend_q + 1'b1 :
             (deq && !enq)          ? pend_q - 1'b1 : pend_q;
    // a drop in the same cycle as a clear keeps the flag set
    ovf_d = drop | (ovf_q & ~overflow_clr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  end
  assign level_out = state_q == HIGH;
  assign busy = state_q != IDLE;
  assign pending_count = pend_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_pulse_to_level.sv
// tb_pulse_to_level: directed checks of window timing, queuing, saturation and reset.
module tb_pulse_to_level;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       level_out, busy, overflow;
  logic [2:0] pending_count;
  int total = 0;
  int bad = 0;

  pulse_to_level dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .overflow_clr(overflow_clr),
    .level_out(level_out), .busy(busy), .pending_count(pending_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pulse_in = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if ({level_out, busy, pending_count, overflow} !== 6'b0) begin
        bad++;
        $display("FAIL reset c=%0d got lvl=%b busy=%b pend=%0d ovf=%b exp all 0",
                 c, level_out, busy, pending_count, overflow);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      total++;
      if (level_out !== (c >= 11 && c <= 14) || busy !== (c >= 11 && c <= 16)) begin
        bad++;
        $display("FAIL single c=%0d got lvl=%b busy=%b exp lvl=%b busy=%b",
                 c, level_out, busy, c >= 11 && c <= 14, c >= 11 && c <= 16);
      end
      pulse_in = (c == 10);
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_queue();
    logic       el, eb;
    logic [2:0] ep;
    do_reset();
    for (int c = 0; c <= 31; c++) begin
      if (c > 0) tick();
      el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26);
      eb = c >= 11 && c <= 28;
      ep = (c == 12) ? 3'd1 : (c >= 13 && c <= 16) ? 3'd2 : (c >= 17 && c <= 22) ? 3'd1 : 3'd0;
      total++;
      if (level_out !== el || busy !== eb || pending_count !== ep) begin
        bad++;
        $display("FAIL queue c=%0d got lvl=%b busy=%b pend=%0d exp lvl=%b busy=%b pend=%0d",
                 c, level_out, busy, pending_count, el, eb, ep);
      end
      pulse_in = (c >= 10 && c <= 12);
    end
    pulse_in = 1'b0;
  endtask

  task automatic test_saturate();
    logic [2:0] ep;
    logic       eo;
    do_reset();
    for (int c = 0; c <= 23; c++) begin
      if (c > 0) tick();
      ep = (c <= 11) ? 3'd0 : (c <= 16) ? 3'(c - 11) : (c == 17) ? 3'd5 :
           (c == 18) ? 3'd6 : (c <= 22) ? 3'd7 : 3'd6;
      eo = (c == 20) || (c >= 22);
      total++;
      if (pending_count !== ep || overflow !== eo) begin
        bad++;
        $display("FAIL saturate c=%0d got pend=%0d ovf=%b exp pend=%0d ovf=%b",
                 c, pending_count, overflow, ep, eo);
      end
      pulse_in = (c >= 10 && c <= 19) || c == 21;
      overflow_clr = (c == 20) || (c == 21);
    end
    pulse_in = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      pulse_in = (c == 10 || c == 11);
    end
    pulse_in = 1'b0;
    total++;
    if (level_out !== 1'b1 || pending_count !== 3'd1) begin
      bad++;
      $display("FAIL premid got lvl=%b pend=%0d exp lvl=1 pend=1", level_out, pending_count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (level_out !== 1'b0 || busy !== 1'b0 || pending_count !== 3'd0) begin
      bad++;
      $display("FAIL async_reset got lvl=%b busy=%b pend=%0d exp 0 0 0",
               level_out, busy, pending_count);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      total++;
      if (level_out !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL no_replay c=%0d got lvl=%b busy=%b exp 0 0", c, level_out, busy);
      end
    end
  endtask

  task automatic test_retrigger();
    logic       el, eb;
    logic [2:0] ep;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) tick();
`ifdef RETRIGGER_EN
      el = c >= 11 && c <= 17;
      eb = c >= 11 && c <= 19;
      ep = 3'd0;
`else
      el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20);
      eb = c >= 11 && c <= 22;
      ep = (c >= 14 && c <= 16) ? 3'd1 : 3'd0;
`endif
      total++;
      if (level_out !== el || busy !== eb || pending_count !== ep) begin
        bad++;
        $display("FAIL retrigger c=%0d got lvl=%b busy=%b pend=%0d exp lvl=%b busy=%b pend=%0d",
                 c, level_out, busy, pending_count, el, eb, ep);
      end
      pulse_in = (c == 10 || c == 13);
    end
    pulse_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_saturate();
    test_reset_mid_window();
    test_retrigger();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
